// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- load/store sequencing controller for the RV32I MEM stage.
//
// Issues exactly one data-memory bus transaction per valid load/store,
// holds the pipeline with `stall` until the transaction completes, formats
// store data/byte strobes and aligns + sign/zero-extends load data.
// Misaligned or illegal accesses and bus timeouts raise a one-cycle o_fault.
//
// Ports
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   i_valid            : MEM-stage instruction valid
//   i_DM_OE / i_DM_WE  : load / store (both set -> treated as store)
//   i_funct3           : access size/sign (B, H, W, BU, HU)
//   i_addr             : byte address
//   i_wdata            : store source data (rs2)
//   stall              : freeze all pipeline registers (combinational)
//   o_DM_data          : formatted load data (registered)
//   o_fault            : one-cycle fault pulse (registered)
//   mem_req_*          : bus request channel (valid/ready handshake)
//   mem_rsp_*          : bus response channel (read data or write ack)
// ---------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255,  // max WAIT cycles before abort, 0 = never
  parameter int CNT_W       = 8     // timeout counter width, 2^CNT_W > TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_DM_OE,
  input  logic        i_DM_WE,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        stall,
  output logic [31:0] o_DM_data,
  output logic        o_fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              req_valid_reg, req_valid_next;
  logic              req_we_reg, req_we_next;
  logic [31:0]       req_addr_reg, req_addr_next;
  logic [31:0]       req_wdata_reg, req_wdata_next;
  logic [3:0]        req_wstrb_reg, req_wstrb_next;
  logic [31:0]       dm_data_reg, dm_data_next;
  logic              fault_reg, fault_next;
  // Access attributes needed when the response comes back.
  logic              ld_reg, ld_next;
  logic [2:0]        f3_reg, f3_next;
  logic [1:0]        lane_reg, lane_next;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic access;
  logic is_store;
  logic size_b, size_h, size_w;
  logic bad_f3, bad_align, bad;

  assign access   = i_valid & (i_DM_OE | i_DM_WE);
  assign is_store = i_DM_WE;  // store wins when both enables are set

  assign size_b = (i_funct3[1:0] == 2'b00);
  assign size_h = (i_funct3[1:0] == 2'b01);
  assign size_w = (i_funct3[1:0] == 2'b10);

  // 011, 11x are never legal; unsigned variants (1xx) make no sense for stores.
  assign bad_f3    = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11) |
                     (is_store & i_funct3[2]);
  assign bad_align = (size_h & i_addr[0]) | (size_w & (i_addr[1:0] != 2'b00));
  assign bad       = bad_f3 | bad_align;

  // -------------------------------------------------------------------------
  // Store formatting: replicate the source across all byte lanes so the
  // strobes alone select the written bytes.
  // -------------------------------------------------------------------------
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    localparam int         HSRC = 8 * (gi % 2);

    assign st_wdata[8*gi +: 8] = size_w ? i_wdata[8*gi +: 8] :
                                 size_h ? i_wdata[HSRC +: 8] :
                                          i_wdata[7:0];

    // Loads never drive strobes.
    assign st_wstrb[gi] = is_store & (size_w |
                                      (size_h & (i_addr[1] == LANE[1])) |
                                      (size_b & (i_addr[1:0] == LANE)));
  end

  // -------------------------------------------------------------------------
  // Load formatting from the latched size/sign and byte offset. Only the low
  // halfword of the shifted word is ever needed for sub-word loads.
  // -------------------------------------------------------------------------
  logic [15:0] sh_lo;
  logic [31:0] ld_fmt;

  assign sh_lo = 16'(mem_rsp_rdata >> {lane_reg, 3'b000});

  always_comb begin
    ld_fmt = mem_rsp_rdata;
    case (f3_reg)
      3'b000:  ld_fmt = {{24{sh_lo[7]}}, sh_lo[7:0]};
      3'b001:  ld_fmt = {{16{sh_lo[15]}}, sh_lo};
      3'b100:  ld_fmt = {24'd0, sh_lo[7:0]};
      3'b101:  ld_fmt = {16'd0, sh_lo};
      default: ld_fmt = mem_rsp_rdata;
    endcase
  end

  // -------------------------------------------------------------------------
  // Timeout: the counter holds the number of WAIT cycles already spent
  // without a response; abort when this cycle would make it TIMEOUT_CYC.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  assign cnt_inc     = cnt_reg + 1'b1;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (32'(cnt_inc) == TIMEOUT_CYC);

  // -------------------------------------------------------------------------
  // FSM: next state, next register values and stall
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    req_valid_next = req_valid_reg;
    req_we_next    = req_we_reg;
    req_addr_next  = req_addr_reg;
    req_wdata_next = req_wdata_reg;
    req_wstrb_next = req_wstrb_reg;
    dm_data_next   = dm_data_reg;
    fault_next     = 1'b0;
    ld_next        = ld_reg;
    f3_next        = f3_reg;
    lane_next      = lane_reg;
    stall          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (access) begin
          if (bad) begin
            // Rejected without bus traffic; the pipeline is not held.
            fault_next = 1'b1;
          end else begin
            stall          = 1'b1;
            state_next     = ST_REQ;
            req_valid_next = 1'b1;
            req_we_next    = is_store;
            req_addr_next  = {i_addr[31:2], 2'b00};
            req_wdata_next = st_wdata;
            req_wstrb_next = st_wstrb;
            ld_next        = ~is_store;
            f3_next        = i_funct3;
            lane_next      = i_addr[1:0];
          end
        end
      end

      ST_REQ: begin
        stall = 1'b1;
        if (mem_req_ready) begin
          req_valid_next = 1'b0;
          cnt_next       = '0;
          state_next     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        stall = 1'b1;
        if (mem_rsp_valid) begin
          if (ld_reg) begin
            dm_data_next = ld_fmt;
          end
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_inc;
          if (timeout_hit) begin
            fault_next   = 1'b1;
            dm_data_next = '0;
            state_next   = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Pipeline advances at the end of this cycle; the held instruction
        // is still on the inputs, so it must not be looked at here.
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      req_valid_reg <= 1'b0;
      req_we_reg    <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      req_wstrb_reg <= '0;
      dm_data_reg   <= '0;
      fault_reg     <= 1'b0;
      ld_reg        <= 1'b0;
      f3_reg        <= '0;
      lane_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_valid_reg <= req_valid_next;
      req_we_reg    <= req_we_next;
      req_addr_reg  <= req_addr_next;
      req_wdata_reg <= req_wdata_next;
      req_wstrb_reg <= req_wstrb_next;
      dm_data_reg   <= dm_data_next;
      fault_reg     <= fault_next;
      ld_reg        <= ld_next;
      f3_reg        <= f3_next;
      lane_reg      <= lane_next;
    end
  end

  assign mem_req_valid = req_valid_reg;
  assign mem_req_we    = req_we_reg;
  assign mem_req_addr  = req_addr_reg;
  assign mem_req_wdata = req_wdata_reg;
  assign mem_req_wstrb = req_wstrb_reg;
  assign o_DM_data     = dm_data_reg;
  assign o_fault       = fault_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// A transaction-level model predicts every output for every cycle; a single
// negedge process compares the DUT against those predictions. Directed
// scenarios add literal expectations, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0, i_DM_OE = 1'b0, i_DM_WE = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic        stall, o_fault;
  logic [31:0] o_DM_data;
  logic        mem_req_valid, mem_req_we;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_DM_OE(i_DM_OE), .i_DM_WE(i_DM_WE),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .stall(stall), .o_DM_data(o_DM_data), .o_fault(o_fault),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model expectations for the current cycle ----------------
  bit          chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_valid = 1'b0, exp_we = 1'b0, exp_fault = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_data = '0;
  logic [3:0]  exp_wstrb = '0;
  bit          chk_wdata = 1'b0;
  bit          fault_next = 1'b0;

  int          stall_seen = 0, valid_seen = 0, fault_seen = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  logic        cap_we = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("o_fault", 32'(o_fault), 32'(exp_fault));
      chk("o_DM_data", o_DM_data, exp_data);
      chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("mem_req_addr", mem_req_addr, exp_addr);
        chk("mem_req_we", 32'(mem_req_we), 32'(exp_we));
        chk("mem_req_wstrb", 32'(mem_req_wstrb), 32'(exp_wstrb));
        if (chk_wdata) chk("mem_req_wdata", mem_req_wdata, exp_wdata);
      end
    end
    if (stall === 1'b1) stall_seen++;
    if (o_fault === 1'b1) fault_seen++;
    if (mem_req_valid === 1'b1) begin
      valid_seen++;
      cap_addr  = mem_req_addr;
      cap_wdata = mem_req_wdata;
      cap_wstrb = mem_req_wstrb;
      cap_we    = mem_req_we;
    end
  end

  // ---------------- reference rules ----------------
  function automatic bit is_bad(input bit store, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int sz;
    legal = store ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz    = 1 << f3[1:0];
    return !legal || ((a % sz) != 0);
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh, b, h;
    sh = rd >> (8 * a[1:0]);
    b  = sh & 32'hFF;
    h  = sh & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128)   ? b - 32'd256   : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] fmt_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'd0:    return (w & 32'hFF) * 32'h01010101;
      3'd1:    return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] fmt_wstrb(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << a[1:0]);
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    exp_fault  = fault_next;
    fault_next = 1'b0;
  endtask

  task automatic clr_cnt();
    stall_seen = 0;
    valid_seen = 0;
    fault_seen = 0;
  endtask

  // Non-access inputs plus stray bus strobes that must be ignored.
  task automatic idle_inputs();
    i_valid = 1'($urandom);
    if (i_valid) begin
      i_DM_OE = 1'b0;
      i_DM_WE = 1'b0;
    end else begin
      i_DM_OE = 1'($urandom);
      i_DM_WE = 1'($urandom);
    end
    i_funct3      = 3'($urandom);
    i_addr        = $urandom;
    i_wdata       = $urandom;
    mem_req_ready = 1'($urandom);
    mem_rsp_valid = ($urandom % 4) == 0;
    mem_rsp_rdata = $urandom;
  endtask

  task automatic idle_cycle();
    step();
    idle_inputs();
    exp_stall = 1'b0;
    exp_valid = 1'b0;
  endtask

  // One complete access from its IDLE cycle through DONE (or rejection).
  // rsp_dly = WAIT cycles without response before the response arrives.
  task automatic do_access(input bit store, input bit both, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int rdy_dly, input int rsp_dly, input logic [31:0] rd);
    bit bad;
    bit timeout;
    bad     = is_bad(store, f3, a);
    timeout = 1'b0;
    step();
    idle_inputs();
    i_valid   = 1'b1;
    i_DM_WE   = store;
    i_DM_OE   = !store || both;
    i_funct3  = f3;
    i_addr    = a;
    i_wdata   = wd;
    exp_stall = !bad;
    exp_valid = 1'b0;
    if (bad) begin
      fault_next = 1'b1;
      return;
    end
    exp_we    = store;
    exp_addr  = {a[31:2], 2'b00};
    exp_wstrb = store ? fmt_wstrb(f3, a) : 4'b0000;
    exp_wdata = fmt_wdata(f3, wd);
    chk_wdata = store;
    for (int i = 0; i <= rdy_dly; i++) begin
      step();
      mem_req_ready = (i == rdy_dly);
      mem_rsp_valid = ($urandom % 3) == 0;
      mem_rsp_rdata = $urandom;
      exp_stall     = 1'b1;
      exp_valid     = 1'b1;
    end
    for (int i = 0; i < 1000; i++) begin
      step();
      mem_req_ready = 1'($urandom);
      exp_stall     = 1'b1;
      exp_valid     = 1'b0;
      if (i == rsp_dly) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rd;
        break;
      end
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
      if (TO != 0 && i + 1 == TO) begin
        timeout = 1'b1;
        break;
      end
    end
    fault_next = timeout;
    step();
    mem_rsp_valid = 1'($urandom);
    mem_rsp_rdata = $urandom;
    mem_req_ready = 1'($urandom);
    exp_stall     = 1'b0;
    exp_valid     = 1'b0;
    if (timeout)     exp_data = '0;
    else if (!store) exp_data = fmt_load(f3, a, rd);
  endtask

  // Start an LW, then reset it asynchronously in REQ or WAIT.
  task automatic reset_during(input bit in_wait, input string tag);
    step();
    i_valid = 1'b1; i_DM_OE = 1'b1; i_DM_WE = 1'b0; i_funct3 = 3'd2; i_addr = 32'h300;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    exp_stall = 1'b1; exp_valid = 1'b0;
    step();
    mem_req_ready = in_wait;
    exp_stall = 1'b1; exp_valid = 1'b1; exp_we = 1'b0;
    exp_addr = 32'h300; exp_wstrb = 4'b0000; chk_wdata = 1'b0;
    if (in_wait) begin
      step();
      mem_req_ready = 1'b0;
      exp_valid = 1'b0;
    end
    #2;
    chk_en  = 1'b0;
    rst     = 1'b1;
    i_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_addr"},  mem_req_addr, 32'd0);
    chk({tag, "_wstrb"}, 32'(mem_req_wstrb), 32'd0);
    chk({tag, "_data"},  o_DM_data, 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h12345678;
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    chk({tag, "_stray_data"},  o_DM_data, 32'd0);
    chk({tag, "_stray_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_stray_fault"}, 32'(o_fault), 32'd0);
    exp_data = '0; exp_fault = 1'b0; fault_next = 1'b0;
    exp_stall = 1'b0; exp_valid = 1'b0;
    chk_en = 1'b1;
  endtask

  logic [2:0]  t2_f3  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
  logic [31:0] t2_addr[4] = '{32'h103, 32'h103, 32'h102, 32'h102};
  logic [31:0] t2_exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "simulation did not finish");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_we",    32'(mem_req_we), 32'd0);
    chk("rst_addr",  mem_req_addr, 32'd0);
    chk("rst_wdata", mem_req_wdata, 32'd0);
    chk("rst_wstrb", 32'(mem_req_wstrb), 32'd0);
    chk("rst_data",  o_DM_data, 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: LW, immediate ready, response in first WAIT cycle
    idle_cycle();
    clr_cnt();
    do_access(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    idle_cycle();
    chk("t1_data",   o_DM_data, 32'hDEADBEEF);
    chk("t1_stalls", 32'(stall_seen), 32'd3);
    chk("t1_addr",   cap_addr, 32'h100);
    chk("t1_wstrb",  32'(cap_wstrb), 32'd0);

    // 2: sub-word loads
    for (int k = 0; k < 4; k++) begin
      do_access(1'b0, 1'b0, t2_f3[k], t2_addr[k], 32'h0, 0, 0, 32'h80FF7F01);
      idle_cycle();
      chk($sformatf("t2_load%0d", k), o_DM_data, t2_exp[k]);
    end

    // 3: SB then SH
    do_access(1'b1, 1'b0, 3'd0, 32'h201, 32'h556677AB, 0, 1, 32'h0);
    idle_cycle();
    chk("t3_sb_wdata", cap_wdata, 32'hABABABAB);
    chk("t3_sb_wstrb", 32'(cap_wstrb), 32'b0010);
    chk("t3_sb_we",    32'(cap_we), 32'd1);
    do_access(1'b1, 1'b0, 3'd1, 32'h202, 32'h99991234, 1, 0, 32'h0);
    idle_cycle();
    chk("t3_sh_wdata", cap_wdata, 32'h12341234);
    chk("t3_sh_wstrb", 32'(cap_wstrb), 32'b1100);
    chk("t3_data_kept", o_DM_data, 32'h000080FF);

    // 4: ready held low 5 cycles
    clr_cnt();
    do_access(1'b0, 1'b0, 3'd2, 32'h444, 32'h0, 5, 1, 32'hCAFEF00D);
    idle_cycle();
    chk("t4_valid_cycles", 32'(valid_seen), 32'd6);
    chk("t4_stalls",       32'(stall_seen), 32'd9);
    chk("t4_data",         o_DM_data, 32'hCAFEF00D);

    // 5: illegal accesses, then a timeout
    clr_cnt();
    do_access(1'b0, 1'b0, 3'd2, 32'h102, 32'h0, 0, 0, 32'h0);
    do_access(1'b0, 1'b0, 3'd1, 32'h101, 32'h0, 0, 0, 32'h0);
    do_access(1'b0, 1'b0, 3'd3, 32'h100, 32'h0, 0, 0, 32'h0);
    do_access(1'b1, 1'b0, 3'd4, 32'h100, 32'h0, 0, 0, 32'h0);
    idle_cycle();
    idle_cycle();
    chk("t5_faults", 32'(fault_seen), 32'd4);
    chk("t5_valid",  32'(valid_seen), 32'd0);
    chk("t5_stalls", 32'(stall_seen), 32'd0);
    clr_cnt();
    do_access(1'b0, 1'b0, 3'd2, 32'h500, 32'h0, 0, 99, 32'h11111111);
    idle_cycle();
    chk("t5_to_fault",  32'(fault_seen), 32'd1);
    chk("t5_to_data",   o_DM_data, 32'd0);
    chk("t5_to_stalls", 32'(stall_seen), 32'd6);

    // 6: reset mid-transaction, stray response, then a normal LW
    do_access(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    reset_during(1'b0, "t6_req");
    do_access(1'b0, 1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
    reset_during(1'b1, "t6_wait");
    do_access(1'b0, 1'b0, 3'd2, 32'h304, 32'h0, 1, 2, 32'h0BADF00D);
    idle_cycle();
    chk("t6_after_data", o_DM_data, 32'h0BADF00D);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom % 8 == 0) begin
        idle_cycle();
      end else begin
        bit          st, both;
        logic [2:0]  f3;
        logic [31:0] a;
        st   = 1'($urandom);
        both = st && ($urandom % 3 == 0);
        f3   = 3'($urandom);
        if ($urandom % 4 != 0) begin
          if (st) f3 = 3'($urandom % 3);
          else    f3 = (f3 == 3'd3 || f3 >= 3'd6) ? 3'd2 : f3;
        end
        a = $urandom;
        if ($urandom % 2 == 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
        do_access(st, both, f3, a, $urandom, int'($urandom % 4), int'($urandom % 6), $urandom);
      end
    end
    idle_cycle();
    idle_cycle();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencing controller between the EX/MEM stage and the data-memory bus of the RV32I core. It issues one data-memory transaction per load/store and holds the pipeline via `stall` until the transaction completes. It formats store data and byte strobes, aligns and sign/zero-extends load data into `o_DM_data`, which feeds the write-back stage's `i_DM_data`. It also flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles spent in WAIT before abort. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- i_valid, input, 1: instruction in the MEM stage is valid.
- i_DM_OE, input, 1: instruction is a load.
- i_DM_WE, input, 1: instruction is a store.
- i_funct3, input, 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr, input, 32: byte address (ALU result).
- i_wdata, input, 32: store source rs2.
- stall, output, 1: freeze all pipeline registers, including mem_wb.
- o_DM_data, output, 32: formatted load data, registered.
- o_fault, output, 1: one-cycle pulse on misaligned, illegal or timed-out access.
- mem_req_valid, output, 1: bus request valid.
- mem_req_ready, input, 1: bus accepts the request.
- mem_req_we, output, 1: 1 = write.
- mem_req_addr, output, 32: word address, {i_addr[31:2], 2'b00}.
- mem_req_wdata, output, 32: replicated store data.
- mem_req_wstrb, output, 4: byte enables. 0000 for reads.
- mem_rsp_valid, input, 1: read data or write acknowledge.
- mem_rsp_rdata, input, 32: read data.

Behaviour:
- Reset values (asynchronous): state IDLE; mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb, o_DM_data, o_fault and the timeout counter all 0.
- `access` = i_valid & (i_DM_OE | i_DM_WE).
- If i_DM_OE and i_DM_WE are both set, the access is a store.
- `bad` is set when any of the following holds:
  - funct3 is 011, 110 or 111, or is 100/101 on a store;
  - H/HU with addr[0] = 1;
  - W with addr[1:0] != 0.
- States:
  - IDLE:
    - `access & !bad`: latch the request fields, go to REQ. `stall` = 1 combinationally in this cycle.
    - `access & bad`: no bus traffic, o_fault = 1 next cycle, remain in IDLE, `stall` = 0.
    - Otherwise: `stall` = 0.
  - REQ:
    - mem_req_valid = 1; all request fields stay stable until `mem_req_ready`.
    - On `mem_req_ready`: clear mem_req_valid, clear the counter, go to WAIT.
    - `stall` = 1.
  - WAIT:
    - On `mem_rsp_valid`, for a load: o_DM_data <= formatted data. For a store: o_DM_data unchanged. Go to DONE.
    - Otherwise increment the counter. If TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC: o_fault pulse, o_DM_data <= 0, go to DONE.
    - `stall` = 1.
  - DONE:
    - `stall` = 0, so the pipeline advances at the end of this cycle.
    - The held instruction is not re-issued. Always go to IDLE.
- Load formatting: sh = rdata >> (8*addr[1:0]).
  - B: sign-extend sh[7:0]. BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0]. HU: zero-extend sh[15:0].
  - W: rdata.
- Store formatting:
  - B: wdata = {4{i_wdata[7:0]}}, wstrb = 0001 << addr[1:0].
  - H: wdata = {2{i_wdata[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - W: wdata = i_wdata, wstrb = 1111.
- Latency: with ready in the REQ cycle and a response in the first WAIT cycle, `stall` is high for 3 cycles (IDLE, REQ, WAIT). o_DM_data is valid from the DONE cycle onward.
- Boundary conditions:
  - mem_rsp_valid in IDLE, REQ or DONE: ignored.
  - mem_req_ready while not requesting: ignored.
  - Reset mid-transaction: returns to IDLE immediately and drops mem_req_valid. A late response after reset is ignored.
  - Back-to-back accesses: the next access is accepted in the IDLE cycle after DONE.
  - o_fault never asserts together with mem_req_valid on a new request.

Test Plan:
1. LW, addr 0x100, ready immediate, rsp rdata 0xDEADBEEF one cycle later → mem_req_addr 0x100, wstrb 0000; stall high exactly 3 cycles; o_DM_data = 0xDEADBEEF in DONE.
2. LB/LBU/LH/LHU, addr 0x103/0x103/0x102/0x102, rdata 0x80FF7F01 → 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF.
3. SB 0xAB to 0x201, then SH 0x1234 to 0x202 → wdata 0xABABABAB with wstrb 0010; then wdata 0x12341234 with wstrb 1100; each completes on write ack.
4. mem_req_ready held low 5 cycles → mem_req_valid and all request fields stable for 6 cycles; stall stays high until DONE.
5. LW at 0x102, LH at 0x101, funct3 011 → one-cycle o_fault each, no mem_req_valid, stall never asserted. With TIMEOUT_CYC = 4 and no response → o_fault after 4 WAIT cycles, o_DM_data = 0, then IDLE.
6. rst asserted during WAIT, then a stray mem_rsp_valid → outputs return to reset values asynchronously; the stray response is ignored; the next LW completes normally.
